bit_serial_alu_ctrl: RTL and testbench
======================================

// Module: bit_serial_alu_ctrl
// PURPOSE
//  Sequencer that time-multiplexes one 1-bit Full_Adder_Sub cell to perform a WIDTH-bit ADD/SUB/SLT, LSB first.
//  Used as the low-area EX-stage ALU option: accepts a funct code and two operands, runs one bit per clock,
//  then returns the result with a done pulse and status flags.
// PARAMETERS
//  WIDTH   32               operand/result width in bits (>=2)
//  CNT_W   $clog2(WIDTH)    bit-counter width
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous, active-low reset
//  start     in   1      request; sampled only when not busy
//  funct     in   6      100000 ADD, 100010 SUB, 101010 SLT; other values are illegal
//  src_a     in   WIDTH  operand A, sampled with start
//  src_b     in   WIDTH  operand B, sampled with start
//  busy      out  1      high in RUN
//  done      out  1      1-cycle pulse; result and flags are valid from this cycle onward
//  result    out  WIDTH  held until the next accepted start
//  zero      out  1      result == 0
//  overflow  out  1      signed overflow of A+B or A-B; 0 for SLT result word and for illegal funct
//  err       out  1      illegal funct; held with result
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; busy, done, err, overflow = 0; zero = 1; result = 0; counter = 0.
//  States IDLE, RUN, DONE:
//   IDLE/DONE + start, legal funct   -> RUN; latch funct, A and B into shift regs; count=0; carry=0 (ADD), 1 (SUB/SLT).
//   IDLE/DONE + start, illegal funct -> DONE; result=0, err=1, overflow=0, done=1 on the next cycle.
//   RUN: each cycle the cell gets a=A[0], b=B[0], c=carry, Signal=latched funct. Sum shifts into result MSB,
//        A and B shift right, carry<=cout, count++. Carry-in of the last bit is saved as c_msb.
//   RUN with count==WIDTH-1 -> DONE on the next edge.
//   DONE: done=1 for exactly one cycle, then IDLE unless start is high.
//  Latency: start high at edge 0 gives busy high in cycles 1..WIDTH and done high in cycle WIDTH+1.
//   Back-to-back: start high during DONE is accepted, so the next RUN begins in the following cycle.
//  start while busy is ignored; no queueing. src/funct may change freely after acceptance.
//  Flags, computed at the RUN->DONE transition:
//   overflow_raw = c_msb ^ final carry.
//   ADD/SUB: overflow = overflow_raw.
//   SLT: result = {WIDTH-1 zeros, diff_msb ^ overflow_raw}; overflow = 0.
//   zero = (final result == 0); err = 0 for legal ops.
//  Result is built in place: the shift reg reaches its final value on the last RUN edge, and the SLT
//   substitution is applied on that same edge. result must never expose partial bits while done=1.
//  rst_n low mid-RUN aborts the op immediately to the reset values. No partial result survives.
//  Arithmetic is modulo 2^WIDTH; the carry out of the MSB is discarded except for the flag.
// STRUCTURE
//  Shared include alu_defs.vh: FUNCT_ADD/SUB/SLT constants and the 2-bit state encoding (IDLE=0, RUN=1, DONE=2).
//   The EX stage and the decoder use the same include.
//  One sub-module: Full_Adder_Sub, instantiated once, fed by the operand LSBs, the carry reg and the latched funct.
//  Everything else (FSM, counter, shift regs, flag logic) lives inline in this module.
// TESTING (WIDTH=32)
//  ADD 5+3: start at edge 0 -> busy cycles 1..32; done cycle 33, result=0x00000008, zero=0, overflow=0, err=0.
//  SUB 3-5 -> result=0xFFFFFFFE, overflow=0. SUB 7-7 -> result=0, zero=1.
//  ADD 0x7FFFFFFF+1 -> 0x80000000, overflow=1. SUB 0x80000000-1 -> 0x7FFFFFFF, overflow=1.
//  SLT 0x80000000,1 -> 0x00000001. SLT 5,3 -> 0. SLT 0x7FFFFFFF,0xFFFFFFFF (overflow case) -> 0.
//  funct 100100 -> done next cycle with err=1, result=0; then start ADD 1+1 during DONE -> 2, err=0.
//  start pulsed at RUN cycle 5 -> ignored, result unchanged. rst_n low at RUN cycle 10 -> busy=0, result=0 at once;
//   a new op after release computes correctly.

Source files
------------

// File: rtl/bit_serial_alu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_ctrl_pkg
// Brief    : Shared funct codes, FSM state encoding and decode helpers for
//            the bit-serial EX-stage ALU.
// Revision : 1.0  initial release
// ============================================================================
package bit_serial_alu_ctrl_pkg;

  // R-type funct codes understood by the serial ALU
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Sequencer states (encoding shared with the decoder and EX stage)
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // True for the three operations the serial datapath can execute
  function automatic logic funct_is_legal(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_SUB) || (funct == FUNCT_SLT);
  endfunction

  // SUB and SLT both need B inverted with a carry-in of one
  function automatic logic funct_is_sub(input logic [5:0] funct);
    return (funct != FUNCT_ADD);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bit_serial_alu_ctrl_full_adder_sub.sv
`default_nettype none
// ============================================================================
// Module   : Full_Adder_Sub
// Brief    : One-bit full adder with conditional B inversion. Adds for ADD,
//            computes a + ~b + c for SUB/SLT.
// Revision : 1.0  initial release
// ============================================================================
module Full_Adder_Sub
  import bit_serial_alu_ctrl_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       c_i,
  input  logic [5:0] signal_i,
  output logic       sum_o,
  output logic       cout_o
);

  logic b_eff_w;

  // Pure combinational bit cell
  always_comb begin
    b_eff_w = b_i ^ funct_is_sub(signal_i);
    sum_o   = a_i ^ b_eff_w ^ c_i;
    cout_o  = (a_i & b_eff_w) | (a_i & c_i) | (b_eff_w & c_i);
  end

endmodule
`default_nettype wire

// File: rtl/bit_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bit_serial_alu_ctrl
// Brief    : Sequencer that time-multiplexes a single Full_Adder_Sub cell to
//            perform WIDTH-bit ADD/SUB/SLT, LSB first, one bit per clock.
//            Returns the result with a one-cycle done pulse and flags.
// Revision : 1.0  initial release
// ============================================================================
module bit_serial_alu_ctrl
  import bit_serial_alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o,
  output logic             overflow_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             carry_q;
  logic [5:0]       funct_q;
  logic             busy_q;
  logic             done_q;
  logic             zero_q;
  logic             ovf_q;
  logic             err_q;

  logic             sum_w;
  logic             cout_w;
  logic [WIDTH-1:0] res_shift_d;
  logic [WIDTH-1:0] res_final_d;
  logic             ovf_raw_d;

  // Single shared bit cell, fed from the operand LSBs and the carry register
  Full_Adder_Sub u_fas (
    .a_i      (a_q[0]),
    .b_i      (b_q[0]),
    .c_i      (carry_q),
    .signal_i (funct_q),
    .sum_o    (sum_w),
    .cout_o   (cout_w)
  );

  // Next result word; on the last RUN edge carry_q is the MSB carry-in
  always_comb begin
    res_shift_d = {sum_w, res_q[WIDTH-1:1]};
    ovf_raw_d   = carry_q ^ cout_w;
    res_final_d = res_shift_d;
    if (funct_q == FUNCT_SLT) begin
      res_final_d = {{(WIDTH-1){1'b0}}, sum_w ^ ovf_raw_d};
    end
  end

  // Sequencer FSM with datapath registers and registered outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      funct_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            if (funct_is_legal(funct_i)) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
              funct_q <= funct_i;
              a_q     <= src_a_i;
              b_q     <= src_b_i;
              cnt_q   <= '0;
              carry_q <= funct_is_sub(funct_i);
            end else begin
              // Illegal op completes immediately with an error result
              state_q <= ST_DONE;
              done_q  <= 1'b1;
              res_q   <= '0;
              zero_q  <= 1'b1;
              ovf_q   <= 1'b0;
              err_q   <= 1'b1;
            end
          end else begin
            state_q <= ST_IDLE;
          end
        end

        ST_RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= cout_w;
          cnt_q   <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            // Result and flags become final on the same edge done rises
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            res_q   <= res_final_d;
            zero_q  <= (res_final_d == '0);
            ovf_q   <= (funct_q == FUNCT_SLT) ? 1'b0 : ovf_raw_d;
            err_q   <= 1'b0;
          end else begin
            res_q   <= res_shift_d;
          end
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign result_o   = res_q;
  assign zero_o     = zero_q;
  assign overflow_o = ovf_q;
  assign err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_bit_serial_alu_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bit_serial_alu_ctrl
// Brief    : Directed self-checking bench for bit_serial_alu_ctrl (WIDTH=32).
// Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_bit_serial_alu_ctrl;

  localparam int W = 32;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_BAD = 6'b100100;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [5:0]   funct = '0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic         busy, done, zero, overflow, err;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;
  int lat, nbusy;

  bit_serial_alu_ctrl #(.WIDTH(W)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .start_i    (start),
    .funct_i    (funct),
    .src_a_i    (src_a),
    .src_b_i    (src_b),
    .busy_o     (busy),
    .done_o     (done),
    .result_o   (result),
    .zero_o     (zero),
    .overflow_o (overflow),
    .err_o      (err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request for one cycle; returns #1 after the accepting edge
  task automatic start_op(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    funct = f; src_a = a; src_b = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    funct = $urandom; src_a = $urandom; src_b = $urandom;
  endtask

  // Bounded wait for done; counts edges and sampled busy cycles
  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    if (busy) nb++;
    while (!done && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (busy) nb++;
    end
  endtask

  task automatic run_check(input string tag, input logic [5:0] f, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [W-1:0] exp_res,
                           input logic exp_zero, input logic exp_ovf, input logic exp_err,
                           input int exp_lat);
    start_op(f, a, b);
    wait_done(lat, nbusy);
    chk({tag, "_lat"}, W'(lat), W'(exp_lat));
    chk({tag, "_busy"}, W'(nbusy), W'(exp_lat));
    chk({tag, "_done"}, W'(done), W'(1));
    chk({tag, "_res"}, result, exp_res);
    chk({tag, "_zero"}, W'(zero), W'(exp_zero));
    chk({tag, "_ovf"}, W'(overflow), W'(exp_ovf));
    chk({tag, "_err"}, W'(err), W'(exp_err));
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_done", W'(done), W'(0));
    chk("rst_res", result, 32'h0);
    chk("rst_zero", W'(zero), W'(1));
    chk("rst_ovf", W'(overflow), W'(0));
    chk("rst_err", W'(err), W'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_check("add_5_3", F_ADD, 32'd5, 32'd3, 32'h00000008, 1'b0, 1'b0, 1'b0, 32);
    // done is a single-cycle pulse; result is held afterwards
    @(posedge clk); #1;
    chk("done_pulse", W'(done), W'(0));
    chk("res_hold", result, 32'h00000008);

    run_check("sub_3_5", F_SUB, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0, 32);
    run_check("sub_7_7", F_SUB, 32'd7, 32'd7, 32'h00000000, 1'b1, 1'b0, 1'b0, 32);
    run_check("add_ovf", F_ADD, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1'b0, 1'b1, 1'b0, 32);
    run_check("sub_ovf", F_SUB, 32'h80000000, 32'h1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0, 32);
    run_check("slt_neg", F_SLT, 32'h80000000, 32'h1, 32'h00000001, 1'b0, 1'b0, 1'b0, 32);
    run_check("slt_5_3", F_SLT, 32'd5, 32'd3, 32'h00000000, 1'b1, 1'b0, 1'b0, 32);
    run_check("slt_ovf", F_SLT, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 32);

    // Illegal funct, then back-to-back ADD accepted during DONE
    run_check("illegal", F_BAD, 32'd9, 32'd9, 32'h00000000, 1'b1, 1'b0, 1'b1, 0);
    run_check("b2b_add", F_ADD, 32'd1, 32'd1, 32'h00000002, 1'b0, 1'b0, 1'b0, 32);

    // start while busy is ignored
    start_op(F_ADD, 32'h10, 32'h20);
    repeat (5) @(posedge clk);
    #1;
    funct = F_SUB; src_a = 32'hDEAD0000; src_b = 32'h0000BEEF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, nbusy);
    chk("ign_lat", W'(lat), W'(26));
    chk("ign_res", result, 32'h00000030);
    chk("ign_err", W'(err), W'(0));
    @(posedge clk); #1;
    chk("ign_idle_busy", W'(busy), W'(0));

    // Asynchronous reset mid-RUN
    start_op(F_ADD, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", W'(busy), W'(0));
    chk("abort_res", result, 32'h0);
    chk("abort_done", W'(done), W'(0));
    chk("abort_zero", W'(zero), W'(1));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_check("post_rst", F_ADD, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0, 1'b0, 1'b0, 32);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
